// File: rtl/ip_gpio_pkg.sv
// Shared constants for the multi-port GPIO: register offsets within a port
// and the largest supported port count.
package ip_gpio_pkg;

  localparam int PORTS_MAX = 4;

  localparam logic [2:0] OFS_OUT   = 3'd0;
  localparam logic [2:0] OFS_DIR   = 3'd1;
  localparam logic [2:0] OFS_PIN   = 3'd2;
  localparam logic [2:0] OFS_IFLAG = 3'd3;
  localparam logic [2:0] OFS_IEN   = 3'd4;
  localparam logic [2:0] OFS_IEDGE = 3'd5;

endpackage

// File: rtl/ip_gpio_port.sv
// One 8-bit GPIO port: output/direction/interrupt registers, a 2-FF pin
// synchroniser with a history stage, and per-bit selectable edge flags.
module ip_gpio_port
  import ip_gpio_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       armed,
  input  logic       wr_en,
  input  logic [2:0] ofs,
  input  logic [7:0] wdata,
  input  logic [7:0] gpi,
  output logic [7:0] gpo,
  output logic [7:0] gpo_oe,
  output logic [7:0] rdata,
  output logic       irq
);

  logic [7:0] out_r;
  logic [7:0] dir_r;
  logic [7:0] iflag_r;
  logic [7:0] ien_r;
  logic [7:0] iedge_r;
  logic [7:0] sync1_r;
  logic [7:0] sync_r;
  logic [7:0] prev_r;
  logic [7:0] edge_s;
  logic [7:0] set_s;
  logic [7:0] clr_s;

  // Edges come only from sync/prev, so flipping IEDGE alone cannot raise one.
  assign edge_s = (iedge_r & ~sync_r & prev_r) | (~iedge_r & sync_r & ~prev_r);
  assign set_s  = armed ? edge_s : 8'h00;
  assign clr_s  = (wr_en && (ofs == OFS_IFLAG)) ? wdata : 8'h00;

  assign gpo    = out_r;
  assign gpo_oe = dir_r;
  assign irq    = |(iflag_r & ien_r);

  // Software-writable configuration registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_r   <= 8'h00;
      dir_r   <= 8'h00;
      ien_r   <= 8'h00;
      iedge_r <= 8'h00;
    end else if (wr_en) begin
      case (ofs)
        OFS_OUT:   out_r   <= wdata;
        OFS_DIR:   dir_r   <= wdata;
        OFS_IEN:   ien_r   <= wdata;
        OFS_IEDGE: iedge_r <= wdata;
        default:   out_r   <= out_r;
      endcase
    end
  end

  // Pin synchroniser and edge history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 8'h00;
      sync_r  <= 8'h00;
      prev_r  <= 8'h00;
    end else begin
      sync1_r <= gpi;
      sync_r  <= sync1_r;
      prev_r  <= sync_r;
    end
  end

  // Edge flags: W1C clear, with a simultaneous set taking priority
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iflag_r <= 8'h00;
    end else begin
      iflag_r <= (iflag_r & ~clr_s) | set_s;
    end
  end

  // Register read mux
  always_comb begin
    rdata = 8'h00;
    case (ofs)
      OFS_OUT:   rdata = out_r;
      OFS_DIR:   rdata = dir_r;
      OFS_PIN:   rdata = sync_r;
      OFS_IFLAG: rdata = iflag_r;
      OFS_IEN:   rdata = ien_r;
      OFS_IEDGE: rdata = iedge_r;
      default:   rdata = 8'h00;
    endcase
  end

endmodule

// File: rtl/ip_gpio_multi.sv
// Multi-port I/O-mapped GPIO on the MSX-50BUS slave interface: bus strobe
// conversion, address decode, power-up arming and the shared interrupt line.
module ip_gpio_multi
  import ip_gpio_pkg::*;
#(
  parameter logic [7:0] io_address = 8'h10,
  parameter int         PORTS      = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               iorq_n,
  input  logic [7:0]         address,
  input  logic               rd_n,
  input  logic               wr_n,
  input  logic [7:0]         d,
  output logic [7:0]         q,
  output logic               q_en,
  output logic [8*PORTS-1:0] gpo,
  output logic [8*PORTS-1:0] gpo_oe,
  input  logic [8*PORTS-1:0] gpi,
  output logic               int_n
);

  if ((PORTS < 1) || (PORTS > PORTS_MAX)) begin : g_bad_ports
    $error("ip_gpio_multi: PORTS out of range");
  end

  logic             iorq_n_r;
  logic             wr_n_r;
  logic             rd_n_r;
  logic [1:0]       arm_cnt_r;
  logic             armed_s;
  logic             w_wr_s;
  logic             w_rd_s;
  logic             hit_s;
  logic [4:0]       rel_s;
  logic [1:0]       port_sel_s;
  logic [2:0]       reg_ofs_s;
  logic [7:0]       port_rdata_s [PORTS];
  logic [PORTS-1:0] irq_s;
  logic [7:0]       rd_mux_s;

  assign w_wr_s = ~iorq_n_r & ~wr_n_r & wr_n;
  assign w_rd_s = ~iorq_n & rd_n_r & ~rd_n;

  // Base is 8-aligned, so the low five bits of the difference give port and offset.
  assign hit_s      = ({1'b0, address} >= {1'b0, io_address}) &&
                      ({1'b0, address} <  ({1'b0, io_address} + 9'(8 * PORTS)));
  assign rel_s      = address[4:0] - io_address[4:0];
  assign port_sel_s = rel_s[4:3];
  assign reg_ofs_s  = rel_s[2:0];
  assign armed_s    = (arm_cnt_r == 2'd3);

  // Bus strobe history for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iorq_n_r <= 1'b1;
      wr_n_r   <= 1'b1;
      rd_n_r   <= 1'b1;
    end else begin
      iorq_n_r <= iorq_n;
      wr_n_r   <= wr_n;
      rd_n_r   <= rd_n;
    end
  end

  // Arming delay: blocks flags from pins already high when reset releases
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt_r <= 2'd0;
    end else if (!armed_s) begin
      arm_cnt_r <= arm_cnt_r + 2'd1;
    end
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    ip_gpio_port u_port (
      .clk     (clk),
      .reset_n (reset_n),
      .armed   (armed_s),
      .wr_en   (w_wr_s && hit_s && (port_sel_s == 2'(p))),
      .ofs     (reg_ofs_s),
      .wdata   (d),
      .gpi     (gpi[8*p +: 8]),
      .gpo     (gpo[8*p +: 8]),
      .gpo_oe  (gpo_oe[8*p +: 8]),
      .rdata   (port_rdata_s[p]),
      .irq     (irq_s[p])
    );
  end

  // Port read mux
  always_comb begin
    rd_mux_s = 8'h00;
    for (int i = 0; i < PORTS; i++) begin
      rd_mux_s = rd_mux_s | ((port_sel_s == 2'(i)) ? port_rdata_s[i] : 8'h00);
    end
  end

  // Registered read data, one-cycle pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q    <= 8'h00;
      q_en <= 1'b0;
    end else if (w_rd_s && hit_s) begin
      q    <= rd_mux_s;
      q_en <= 1'b1;
    end else begin
      q    <= 8'h00;
      q_en <= 1'b0;
    end
  end

  // Interrupt request register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      int_n <= 1'b1;
    end else begin
      int_n <= ~|irq_s;
    end
  end

endmodule

// File: tb/tb_ip_gpio_multi.sv
// Self-checking bench for ip_gpio_multi (PORTS=2, base 0x10): table-driven
// register accesses with a read scoreboard, plus interrupt and reset sequences.
module tb_ip_gpio_multi;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        iorq_n;
  logic [7:0]  address;
  logic        rd_n;
  logic        wr_n;
  logic [7:0]  d;
  logic [7:0]  q;
  logic        q_en;
  logic [15:0] gpo;
  logic [15:0] gpo_oe;
  logic [15:0] gpi;
  logic        int_n;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] exp;
  } rd_exp_t;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [15:0] exp_gpo;
    logic [15:0] exp_oe;
  } vec_t;

  rd_exp_t sb[$];
  rd_exp_t mon_e;
  vec_t    vecs[$];
  int      total   = 0;
  int      bad     = 0;
  int      qen_cnt = 0;

  ip_gpio_multi #(.io_address(8'h10), .PORTS(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .iorq_n  (iorq_n),
    .address (address),
    .rd_n    (rd_n),
    .wr_n    (wr_n),
    .d       (d),
    .q       (q),
    .q_en    (q_en),
    .gpo     (gpo),
    .gpo_oe  (gpo_oe),
    .gpi     (gpi),
    .int_n   (int_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every q_en pulse must match the oldest pending read
  always @(negedge clk) begin
    if (q_en === 1'b1) begin
      qen_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_q_en", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("read_%02h", mon_e.addr), {24'h0, q}, {24'h0, mon_e.exp});
      end
    end
  end

  task automatic bus_write(input logic [7:0] a, input logic [7:0] v,
                           input bit chg = 1'b0, input logic [15:0] pins = 16'h0000);
    @(negedge clk);
    if (chg) gpi = pins;
    address = a; d = v; iorq_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    wr_n = 1'b1;
    @(negedge clk);
    iorq_n = 1'b1;
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [7:0] exp);
    rd_exp_t e;
    e.addr = a;
    e.exp  = exp;
    @(negedge clk);
    address = a; iorq_n = 1'b0;
    @(negedge clk);
    rd_n = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    rd_n = 1'b1; iorq_n = 1'b1;
    #1;
    for (int i = 0; i < 4 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check($sformatf("q_en_seen_%02h", a), sb.size(), 32'd0);
    if (sb.size() != 0) sb.delete();
  endtask

  task automatic bus_read_miss(input logic [7:0] a);
    int c0;
    c0 = qen_cnt;
    @(negedge clk);
    address = a; iorq_n = 1'b0;
    @(negedge clk);
    rd_n = 1'b0;
    @(negedge clk);
    rd_n = 1'b1; iorq_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check($sformatf("no_q_en_%02h", a), qen_cnt - c0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    address = 8'h00; d = 8'h00;
    gpi = 16'hFFFF;
    reset_n = 1'b0;

    // Reference table: reset values, OUT/DIR, ignored writes, port 1 access
    for (int a = 8'h10; a <= 8'h1F; a++) vecs.push_back('{1'b0, 8'(a), 8'h00, 16'h0000, 16'h0000});
    vecs.push_back('{1'b1, 8'h10, 8'hA5, 16'h00A5, 16'h0000});
    vecs.push_back('{1'b1, 8'h11, 8'h0F, 16'h00A5, 16'h000F});
    vecs.push_back('{1'b0, 8'h10, 8'hA5, 16'h00A5, 16'h000F});
    vecs.push_back('{1'b0, 8'h11, 8'h0F, 16'h00A5, 16'h000F});
    vecs.push_back('{1'b1, 8'h12, 8'h55, 16'h00A5, 16'h000F});
    vecs.push_back('{1'b0, 8'h12, 8'h00, 16'h00A5, 16'h000F});
    vecs.push_back('{1'b1, 8'h16, 8'h77, 16'h00A5, 16'h000F});
    vecs.push_back('{1'b0, 8'h16, 8'h00, 16'h00A5, 16'h000F});
    vecs.push_back('{1'b1, 8'h18, 8'h3C, 16'h3CA5, 16'h000F});
    vecs.push_back('{1'b0, 8'h18, 8'h3C, 16'h3CA5, 16'h000F});
    vecs.push_back('{1'b1, 8'h19, 8'hF0, 16'h3CA5, 16'hF00F});
    vecs.push_back('{1'b0, 8'h19, 8'hF0, 16'h3CA5, 16'hF00F});
    vecs.push_back('{1'b1, 8'h1C, 8'h5A, 16'h3CA5, 16'hF00F});
    vecs.push_back('{1'b0, 8'h1C, 8'h5A, 16'h3CA5, 16'hF00F});
    vecs.push_back('{1'b1, 8'h1D, 8'hC3, 16'h3CA5, 16'hF00F});
    vecs.push_back('{1'b0, 8'h1D, 8'hC3, 16'h3CA5, 16'hF00F});
    vecs.push_back('{1'b1, 8'h1C, 8'h00, 16'h3CA5, 16'hF00F});
    vecs.push_back('{1'b1, 8'h1D, 8'h00, 16'h3CA5, 16'hF00F});
    vecs.push_back('{1'b1, 8'h19, 8'h00, 16'h3CA5, 16'h000F});
    vecs.push_back('{1'b1, 8'h20, 8'hFF, 16'h3CA5, 16'h000F});
    vecs.push_back('{1'b1, 8'h0F, 8'hFF, 16'h3CA5, 16'h000F});

    repeat (3) @(negedge clk);
    check("rst_int_n", {31'h0, int_n}, 32'd1);
    check("rst_gpo", {16'h0, gpo}, 32'h0);
    check("rst_gpo_oe", {16'h0, gpo_oe}, 32'h0);
    check("rst_q_en", {31'h0, q_en}, 32'd0);
    reset_n = 1'b1;

    // Pins high through reset: visible on PIN but never flagged
    repeat (6) @(negedge clk);
    bus_read(8'h12, 8'hFF);
    bus_read(8'h13, 8'h00);
    bus_read(8'h1A, 8'hFF);
    bus_read(8'h1B, 8'h00);
    check("powerup_int_n", {31'h0, int_n}, 32'd1);
    gpi = 16'h0000;
    repeat (5) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
      else            bus_read(vecs[i].addr, vecs[i].data);
      check($sformatf("vec%0d_gpo", i), {16'h0, gpo}, {16'h0, vecs[i].exp_gpo});
      check($sformatf("vec%0d_gpo_oe", i), {16'h0, gpo_oe}, {16'h0, vecs[i].exp_oe});
    end
    bus_read_miss(8'h20);
    bus_read_miss(8'h0F);

    // Rising edge on gpi[8]: flag at 3 edges, int_n at 4, W1C releases it
    bus_write(8'h1C, 8'h01);
    @(negedge clk);
    gpi[8] = 1'b1;
    repeat (3) @(negedge clk);
    check("irq_3_edges_int_n", {31'h0, int_n}, 32'd1);
    @(negedge clk);
    check("irq_4_edges_int_n", {31'h0, int_n}, 32'd0);
    bus_read(8'h1B, 8'h01);
    bus_read(8'h13, 8'h00);
    bus_write(8'h1B, 8'h01);
    check("w1c_commit_int_n", {31'h0, int_n}, 32'd0);
    @(negedge clk);
    check("w1c_next_int_n", {31'h0, int_n}, 32'd1);

    // Falling-edge mode on port 0
    bus_write(8'h15, 8'hFF);
    @(negedge clk);
    gpi[7:0] = 8'hFF;
    repeat (5) @(negedge clk);
    bus_read(8'h13, 8'h00);
    gpi[7:0] = 8'h00;
    repeat (5) @(negedge clk);
    bus_read(8'h13, 8'hFF);
    check("fall_ien_off_int_n", {31'h0, int_n}, 32'd1);
    gpi[0] = 1'b1;
    repeat (5) @(negedge clk);
    bus_write(8'h13, 8'h0F, 1'b1, {gpi[15:8], 8'h00});
    bus_read(8'h13, 8'hF1);

    // Enable port 0 flags, then pull reset between clock edges
    bus_write(8'h14, 8'hFF);
    @(negedge clk);
    check("pending_int_n", {31'h0, int_n}, 32'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_int_n", {31'h0, int_n}, 32'd1);
    check("async_rst_gpo", {16'h0, gpo}, 32'h0);
    check("async_rst_gpo_oe", {16'h0, gpo_oe}, 32'h0);
    gpi = 16'h0000;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    bus_read(8'h10, 8'h00);
    bus_read(8'h11, 8'h00);
    bus_read(8'h13, 8'h00);
    bus_read(8'h14, 8'h00);
    bus_read(8'h15, 8'h00);
    bus_read(8'h1C, 8'h00);
    check("post_rst_int_n", {31'h0, int_n}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ip_gpio_multi.md
# ip_gpio_multi

Multi-port MSX I/O-mapped GPIO with per-bit direction control, input synchronisation and edge-triggered interrupts. It is the parametrised successor to the single-byte GPIO and sits on the same internal MSX-50BUS slave interface. Its read path is wired into the top-level `q`/`q_en` OR-mux, and `int_n` feeds the CPU interrupt line.

## Interface
- `io_address`, default 8'h10: base I/O address; must be a multiple of 8.
- `PORTS`, default 2: number of 8-bit ports; legal range 1..4; occupies 8*PORTS consecutive addresses.

- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `iorq_n` in 1: bus I/O request.
- `address` in 8: bus address.
- `rd_n` in 1: bus read strobe.
- `wr_n` in 1: bus write strobe.
- `d` in 8: write data.
- `q` out 8: read data; 8'h00 whenever `q_en`=0.
- `q_en` out 1: read data valid, one-cycle pulse.
- `gpo` out 8*PORTS: output data; port p occupies bits [8p+7:8p].
- `gpo_oe` out 8*PORTS: per-bit output enable (1 = drive).
- `gpi` in 8*PORTS: asynchronous pin inputs.
- `int_n` out 1: interrupt request, active-low, registered.

## Operation
- Hit condition: io_address <= address < io_address + 8*PORTS. Port select p = (address - io_address)[4:3]. Register offset = address[2:0].
- Per-port registers:
  - +0 OUT: read/write; drives `gpo`.
  - +1 DIR: read/write; drives `gpo_oe`.
  - +2 PIN: read-only; returns the synchronised `gpi`.
  - +3 IFLAG: read returns pending edge flags; write is write-1-to-clear.
  - +4 IEN: read/write; interrupt enable.
  - +5 IEDGE: read/write; per bit, 0 = rising, 1 = falling.
  - +6 and +7: read 8'h00; writes are ignored.
  - Writes to PIN are ignored.
- Bus write strobe `w_wr` = registered `iorq_n` low AND registered `wr_n` low AND current `wr_n` high, i.e. commit on the rising edge of `wr_n`.
- Bus read strobe `w_rd` = current `iorq_n` low AND registered `rd_n` high AND current `rd_n` low, i.e. the falling edge of `rd_n`.
- Input path:
  - `gpi` passes through a 2-FF synchroniser, giving `sync`.
  - A third FF holds `prev`.
  - Rising edge = `sync` & ~`prev`; falling edge = ~`sync` & `prev`. The polarity is selected per bit by IEDGE.
- IFLAG bit sets on a selected edge regardless of IEN.
- Edge set and W1C clear in the same cycle on the same bit: set wins.
- Changing IEDGE never generates an edge by itself.
- Arming: after reset deassertion, a 2-bit counter counts 3 clocks. No IFLAG bit may set until the counter saturates. This prevents power-up flags from pins that are high at reset.
- `int_n` next = ~|(IFLAG & IEN) over all ports.
- Reset values:
  - OUT, DIR, IFLAG, IEN, IEDGE: 0.
  - Synchroniser chain and `prev`: 0; arm counter: 0.
  - `gpo` = 0, `gpo_oe` = 0 (all ports are inputs).
  - `int_n` = 1, `q` = 0, `q_en` = 0.
- Reset mid-operation: all state returns to the reset values asynchronously; no partial write survives.

## Timing
- Write: registers update on the clock edge at which `w_wr` is high. `gpo`/`gpo_oe` change on that same edge.
- Read: `q` and `q_en` are both registered on the edge at which `w_rd` is high, and hold for exactly one cycle. `q` captures the register value present at that edge.
- Pin change to PIN readable: 2 edges.
- Pin change to IFLAG set: 3 edges.
- Pin change to `int_n` low: 4 edges, provided IEN is set.
- W1C to `int_n` high: `int_n` rises one edge after the IFLAG clear, provided no other enabled flag is pending.
- A read of IFLAG coincident with a set returns the pre-set value.

## Structure
- Shared include/package `ip_gpio_pkg` holds:
  - Register offset constants: OFS_OUT, OFS_DIR, OFS_PIN, OFS_IFLAG, OFS_IEN, OFS_IEDGE.
  - The PORTS maximum.
- Sub-module `ip_gpio_port`, instantiated PORTS times via generate, owns:
  - The 6 registers of one port.
  - That port's synchroniser and edge detector.
  - It outputs its read mux value and its irq term.
- The top level owns the bus pulse conversion, address decode, arm counter, port read mux, and `int_n` register.

## Test plan
- Reset, then read every register of ports 0..1 -> all read 8'h00; `gpo`=0, `gpo_oe`=0, `int_n`=1; pins held at 8'hFF during reset set no IFLAG.
- Write 8'hA5 to 0x10 and 8'h0F to 0x11 -> `gpo[7:0]`=A5 and `gpo_oe[7:0]`=0F after the `wr_n` rise; reading back returns A5 and 0F with `q_en` high for exactly 1 cycle.
- PORTS=2: write 8'h3C to 0x18 -> `gpo[15:8]`=3C; access 0x20 -> no `q_en` and no state change.
- Port 1 with IEN=01 and IEDGE=00, pulse `gpi[8]` 0->1 -> IFLAG(0x1B)=01 at 3 edges; `int_n` low at 4 edges; write 01 to 0x1B -> `int_n` high one edge later.
- Falling-edge mode (IEDGE=FF), `gpi[7:0]` 00->FF->00 -> only the falling transition sets IFLAG=FF; W1C of 8'h0F coincident with a new edge on bit 0 -> IFLAG=F1.
- Assert `reset_n` during a pending interrupt -> `int_n`=1 and all registers 0 immediately, without waiting for a clock edge.
